mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the ControlUnit (fetch, load and store), port 1 is the debug/program loader.
- Grants round-robin, holds one transaction at a time and drives the memory's write/ready handshake.
- Adds a ready-timeout so that a stalled memory produces an error instead of hanging the core.
- Sits between ControlUnit/loader and the memory model; drives the memory's address, write-enable and data inputs and samples its memory_ready.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ready; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  request from the port; held high until the matching ack.
- we0, we1  in  1 each  1 = write, 0 = read; sampled at grant.
- addr0, addr1  in  ADDR_W each  address; sampled at grant.
- wdata0, wdata1  in  DATA_W each  write data; sampled at grant.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- err0, err1  out  1 each  one-cycle pulse coincident with ack; the transaction timed out.
- rdata0, rdata1  out  DATA_W each  read data; valid while ack is high and held afterwards.
- mem_req  out  1  transaction active.
- mem_w  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion; sampled only in BUSY.

Behaviour:
- Reset values: state=IDLE, last_grant=1 (port 0 wins first), all ack/err=0, mem_req=0, mem_w=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0, timeout counter=0.
- FSM has two states, IDLE and BUSY.
- IDLE, eligibility: a port is eligible when its req=1 and its ack is not high this cycle. This gives a one-cycle gap so a requester can drop req on seeing ack.
- IDLE, single eligible port: at the next edge that port is granted.
- IDLE, both ports eligible: the port not equal to last_grant wins.
- IDLE, on grant: latch addr/we/wdata into the mem_* registers; set mem_req=1, mem_w=we, last_grant=winner, counter=0; state goes to BUSY.
- BUSY, mem_ready=1: at that edge ackN=1 and rdataN<=mem_rdata (for writes, rdataN is unchanged); mem_req=0, mem_w=0; state goes to IDLE.
- BUSY, mem_ready=0: counter increments.
- BUSY, timeout: when TIMEOUT!=0 and counter==TIMEOUT-1 with no mem_ready, at that edge ackN=1, errN=1, rdataN<=0, mem_req=0, mem_w=0; state goes to IDLE.
- BUSY, mem_ready coinciding with the timeout edge: mem_ready has precedence and err stays 0.
- Latency: req high in cycle 0 gives mem_req in cycle 1. With a zero-wait memory (mem_ready in cycle 1), ack arrives in cycle 2. Back-to-back grants to the other port are possible from cycle 2 onward.
- mem_addr, mem_wdata and mem_w stay stable for the entire BUSY period. mem_addr and mem_wdata keep their last values in IDLE.
- Requests arriving during BUSY wait and are never dropped. Changes to addr/we/wdata after grant are ignored.
- Asynchronous reset mid-transaction: return immediately to IDLE and the reset values; no ack is issued. The memory write may or may not have completed.
- Counter saturation: the counter is not checked when TIMEOUT=0; it saturates at all-ones instead of wrapping.
- ack and err are registered and never high for both ports in the same cycle.

Decomposition:
- Package mem_arb_pkg: state encoding (ST_IDLE, ST_BUSY) and port index constants (PORT_CU=0, PORT_LDR=1).
- Sub-module rr_arb2: combinational 2-way round-robin pick from eligibility bits plus last_grant. Outputs grant_valid and grant_idx.

Test Plan:
- Reset, then req0 read at addr 16'h0010; memory returns 16'hBEEF with 0 wait states -> mem_req in cycle 1, ack0 in cycle 2, rdata0=16'hBEEF, err0=0.
- req0 and req1 raised in the same cycle with reqs held for 4 transactions (3 wait states each) -> grant order 0,1,0,1; never two acks in one cycle.
- req1 write addr 16'h0100, data 16'h1234, 5 wait states -> mem_w=1 and mem_addr/mem_wdata stable for all 6 BUSY cycles; ack1 follows the mem_ready edge; rdata1 unchanged.
- TIMEOUT=4 and memory never ready -> ack0 and err0 pulse exactly 4 cycles after mem_req rises; rdata0=0; the next request is served normally.
- TIMEOUT=4 with mem_ready on the 4th BUSY cycle -> ack0=1, err0=0, data captured.
- reset asserted asynchronously during BUSY -> mem_req=0 immediately, no ack; after release, pending req1 is granted first (last_grant=1 makes port 0 the priority, but only req1 is high).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port indices for the memory port arbiter
package mem_arb_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
   localparam logic PORT_CU  = 1'b0;
   localparam logic PORT_LDR = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick from eligibility bits and the last winner
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] elig,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_idx
);
   // both eligible: the port that did not win last time; otherwise the lone eligible port
   always_comb begin
      grant_valid = |elig;
      grant_idx   = &elig ? ~last_grant : elig[PORT_LDR];
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a single-port memory between ControlUnit and loader, with ready timeout
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_req,
   output logic              mem_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   localparam logic             TO_EN   = TIMEOUT != 0;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

   state_t           state, state_nxt;
   logic             last_grant, grant_valid, grant_idx;
   logic             grant_fire, done_ok, done_to, done;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       elig;

   // a port is not eligible in its own ack cycle, giving the requester time to drop req
   assign elig = {req1 & ~ack1, req0 & ~ack0};
   assign done = done_ok | done_to;

   rr_arb2 u_rr (
      .elig        (elig),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // grant in IDLE; in BUSY finish on mem_ready, which takes precedence over the timeout
   always_comb begin
      grant_fire = state == ST_IDLE && grant_valid;
      done_ok    = state == ST_BUSY && mem_ready;
      done_to    = state == ST_BUSY && !mem_ready && TO_EN && cnt == TO_LAST;
      state_nxt  = grant_fire ? ST_BUSY : (done_ok || done_to) ? ST_IDLE : state;
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // transaction latch, completion pulses, read data capture and wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_LDR;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         mem_req    <= 1'b0;
         mem_w      <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cnt        <= '0;
      end else begin
         ack0 <= done && last_grant == PORT_CU;
         ack1 <= done && last_grant == PORT_LDR;
         err0 <= done_to && last_grant == PORT_CU;
         err1 <= done_to && last_grant == PORT_LDR;
         if (grant_fire) begin
            last_grant <= grant_idx;
            mem_req    <= 1'b1;
            mem_w      <= grant_idx ? we1 : we0;
            mem_addr   <= grant_idx ? addr1 : addr0;
            mem_wdata  <= grant_idx ? wdata1 : wdata0;
            cnt        <= '0;
         end else if (done) begin
            mem_req <= 1'b0;
            mem_w   <= 1'b0;
            if (last_grant == PORT_CU && (done_to || !mem_w))  rdata0 <= done_to ? '0 : mem_rdata;
            if (last_grant == PORT_LDR && (done_to || !mem_w)) rdata1 <= done_to ? '0 : mem_rdata;
         end else if (state == ST_BUSY && !(&cnt)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the memory port arbiter against a behavioural model
module tb_mem_port_arbiter;
   logic        clk = 1'b0, reset = 1'b1, sel = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic [15:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic [1:0]  a_ack, a_err, b_ack, b_err, ack, err;
   logic [15:0] a_rd0, a_rd1, b_rd0, b_rd1, rd0, rd1;
   logic        a_mreq, a_mw, b_mreq, b_mw, mem_req, mem_w;
   logic [15:0] a_maddr, a_mwd, b_maddr, b_mwd, mem_addr, mem_wdata;
   logic [15:0] mem [16];
   int          wait_cfg = 0, bcnt = 0, checks = 0, fails = 0;
   bit          never_rdy = 1'b0;

   always #5 clk = ~clk;

   // sel picks which instance is stimulated and observed: a = default timeout, b = TIMEOUT 4
   assign ack       = sel ? b_ack : a_ack;
   assign err       = sel ? b_err : a_err;
   assign rd0       = sel ? b_rd0 : a_rd0;
   assign rd1       = sel ? b_rd1 : a_rd1;
   assign mem_req   = sel ? b_mreq : a_mreq;
   assign mem_w     = sel ? b_mw : a_mw;
   assign mem_addr  = sel ? b_maddr : a_maddr;
   assign mem_wdata = sel ? b_mwd : a_mwd;

   mem_port_arbiter dut_a (
      .clk(clk), .reset(reset), .req0(req0 & ~sel), .req1(req1 & ~sel), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(a_ack[0]), .ack1(a_ack[1]), .err0(a_err[0]), .err1(a_err[1]),
      .rdata0(a_rd0), .rdata1(a_rd1), .mem_req(a_mreq), .mem_w(a_mw),
      .mem_addr(a_maddr), .mem_wdata(a_mwd), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   mem_port_arbiter #(.TIMEOUT(4)) dut_b (
      .clk(clk), .reset(reset), .req0(req0 & sel), .req1(req1 & sel), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(b_ack[0]), .ack1(b_ack[1]), .err0(b_err[0]), .err1(b_err[1]),
      .rdata0(b_rd0), .rdata1(b_rd1), .mem_req(b_mreq), .mem_w(b_mw),
      .mem_addr(b_maddr), .mem_wdata(b_mwd), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // memory model: ready on BUSY cycle wait_cfg+1, 16 words indexed by the low address bits
   always @(negedge clk) begin
      if (mem_req && !reset) begin
         bcnt++;
         mem_ready = !never_rdy && bcnt == wait_cfg + 1;
         mem_rdata = mem[mem_addr[3:0]];
         if (mem_ready && mem_w) mem[mem_addr[3:0]] = mem_wdata;
      end else begin
         bcnt = 0;
         mem_ready = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input int p, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic do_reset();
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; never_rdy = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s); #1;
         checks++; if ({ack, err, mem_req, mem_w} !== 6'b0) begin fails++; $display("FAIL reset_ctl[%0d]: got %b want 0", s, {ack, err, mem_req, mem_w}); end
         checks++; if ({mem_addr, mem_wdata} !== 32'h0) begin fails++; $display("FAIL reset_mem[%0d]: got %h want 0", s, {mem_addr, mem_wdata}); end
         checks++; if ({rd0, rd1} !== 32'h0) begin fails++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, {rd0, rd1}); end
      end
      sel = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_read_zero_wait();
      sel = 1'b0; do_reset();
      mem[0] = 16'hBEEF; wait_cfg = 0;
      drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
      tick();
      checks++; if ({mem_req, mem_w, ack[0]} !== 3'b100 || mem_addr !== 16'h0010) begin fails++; $display("FAIL rd0_cycle1: got req/w/ack=%b addr=%h want 100 0010", {mem_req, mem_w, ack[0]}, mem_addr); end
      tick();
      checks++; if (ack[0] !== 1'b1 || err[0] !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL rd0_cycle2: got ack=%b err=%b req=%b want 1 0 0", ack[0], err[0], mem_req); end
      checks++; if (rd0 !== 16'hBEEF) begin fails++; $display("FAIL rd0_data: got %h want BEEF", rd0); end
      req0 = 1'b0;
      tick();
      checks++; if (ack[0] !== 1'b0) begin fails++; $display("FAIL rd0_ack_pulse: got %b want 0", ack[0]); end
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_o[4] = '{0, 1, 0, 1};
      int acks = 0, both = 0;
      logic prev = 1'b0;
      sel = 1'b0; do_reset();
      wait_cfg = 3;
      drive(0, 1'b1, 1'b0, 16'h0001, 16'h0);
      drive(1, 1'b1, 1'b0, 16'h0002, 16'h0);
      for (int c = 0; c < 80 && acks < 4; c++) begin
         tick();
         if (mem_req && !prev) order.push_back(mem_addr == 16'h0002 ? 1 : 0);
         if (&ack) both++;
         if (|ack) acks++;
         if (acks == 4) begin req0 = 1'b0; req1 = 1'b0; end
         prev = mem_req;
      end
      checks++; if (acks != 4 || order.size() != 4) begin fails++; $display("FAIL rr_count: got acks=%0d grants=%0d want 4 4", acks, order.size()); end
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         checks++; if (order[i] != exp_o[i]) begin fails++; $display("FAIL rr_order[%0d]: got port %0d want %0d", i, order[i], exp_o[i]); end
      end
      checks++; if (both != 0) begin fails++; $display("FAIL rr_dual_ack: got %0d cycles want 0", both); end
      tick();
   endtask

   task automatic test_write_stable();
      sel = 1'b0; do_reset();
      mem[5] = 16'hA5A5; wait_cfg = 0;
      drive(1, 1'b1, 1'b0, 16'h0005, 16'h0);
      tick(); tick();
      req1 = 1'b0;
      tick();
      wait_cfg = 5;
      drive(1, 1'b1, 1'b1, 16'h0100, 16'h1234);
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({mem_req, mem_w, ack[1]} !== 3'b110 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1234) begin
            fails++; $display("FAIL wr_stable[%0d]: got req/w/ack=%b addr=%h data=%h want 110 0100 1234", i, {mem_req, mem_w, ack[1]}, mem_addr, mem_wdata);
         end
         drive(1, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
         tick();
      end
      checks++; if ({ack[1], err[1], mem_req, mem_w} !== 4'b1000) begin fails++; $display("FAIL wr_done: got ack/err/req/w=%b want 1000", {ack[1], err[1], mem_req, mem_w}); end
      checks++; if (rd1 !== 16'hA5A5 || mem_addr !== 16'h0100) begin fails++; $display("FAIL wr_hold: got rdata1=%h addr=%h want A5A5 0100", rd1, mem_addr); end
      checks++; if (mem[0] !== 16'h1234) begin fails++; $display("FAIL wr_mem: got %h want 1234", mem[0]); end
      req1 = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      sel = 1'b1; do_reset();
      mem[3] = 16'h5A5A; wait_cfg = 0;
      drive(0, 1'b1, 1'b0, 16'h0003, 16'h0);
      tick(); tick();
      checks++; if (ack[0] !== 1'b1 || rd0 !== 16'h5A5A) begin fails++; $display("FAIL to_pre: got ack=%b rdata0=%h want 1 5A5A", ack[0], rd0); end
      req0 = 1'b0;
      tick();
      never_rdy = 1'b1;
      req0 = 1'b1;
      tick();
      for (int i = 2; i <= 4; i++) begin
         tick();
         checks++; if (ack[0] !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("FAIL to_wait[%0d]: got ack=%b req=%b want 0 1", i, ack[0], mem_req); end
      end
      tick();
      checks++; if ({ack[0], err[0], mem_req} !== 3'b110 || rd0 !== 16'h0) begin fails++; $display("FAIL to_fire: got ack/err/req=%b rdata0=%h want 110 0000", {ack[0], err[0], mem_req}, rd0); end
      req0 = 1'b0; never_rdy = 1'b0;
      tick();
      checks++; if ({ack[0], err[0]} !== 2'b00) begin fails++; $display("FAIL to_pulse: got %b want 00", {ack[0], err[0]}); end
      req0 = 1'b1;
      tick(); tick();
      checks++; if ({ack[0], err[0]} !== 2'b10 || rd0 !== 16'h5A5A) begin fails++; $display("FAIL to_recover: got ack/err=%b rdata0=%h want 10 5A5A", {ack[0], err[0]}, rd0); end
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_timeout_edge();
      sel = 1'b1; do_reset();
      mem[7] = 16'h0F0F; wait_cfg = 3;
      drive(0, 1'b1, 1'b0, 16'h0007, 16'h0);
      tick(); tick(); tick(); tick();
      checks++; if (ack[0] !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("FAIL edge_wait: got ack=%b req=%b want 0 1", ack[0], mem_req); end
      tick();
      checks++; if ({ack[0], err[0]} !== 2'b10 || rd0 !== 16'h0F0F) begin fails++; $display("FAIL edge_ready: got ack/err=%b rdata0=%h want 10 0F0F", {ack[0], err[0]}, rd0); end
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      logic [15:0] exp_a = mem[10];
      sel = 1'b0; do_reset();
      wait_cfg = 20;
      drive(0, 1'b1, 1'b0, 16'h0009, 16'h0);
      tick();
      checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL ar_busy: got %b want 1", mem_req); end
      drive(1, 1'b1, 1'b0, 16'h000A, 16'h0);
      tick();
      #2 reset = 1'b1;
      #1;
      checks++; if ({mem_req, ack, err} !== 5'b0) begin fails++; $display("FAIL ar_immediate: got req/ack/err=%b want 0", {mem_req, ack, err}); end
      req0 = 1'b0; wait_cfg = 0;
      tick();
      reset = 1'b0;
      checks++; if (ack !== 2'b00) begin fails++; $display("FAIL ar_no_ack: got %b want 00", ack); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h000A) begin fails++; $display("FAIL ar_regrant: got req=%b addr=%h want 1 000A", mem_req, mem_addr); end
      tick();
      checks++; if (ack !== 2'b10 || rd1 !== exp_a) begin fails++; $display("FAIL ar_ack1: got ack=%b rdata1=%h want 10 %h", ack, rd1, exp_a); end
      req1 = 1'b0;
      tick();
   endtask

   task automatic test_random(input logic s);
      logic [15:0] ref_mem [16];
      logic [15:0] exp_rd [2];
      logic [15:0] t_addr [2];
      logic [15:0] t_wd [2];
      logic        t_we [2];
      bit          pend [2], granted [2], just [2], pr_req [2], pr_ack [2];
      bit          prev_mreq, run, e0, e1, to;
      int          last_w, cur, busy, cur_wait, limit, g, n;
      sel = s; do_reset();
      ref_mem = mem;
      limit = s ? 4 : 255;
      last_w = 1; cur = 0; busy = 0; cur_wait = 0; prev_mreq = 1'b0;
      for (int p = 0; p < 2; p++) begin
         exp_rd[p] = '0; t_addr[p] = '0; t_wd[p] = '0; t_we[p] = 1'b0;
         pend[p] = 1'b0; granted[p] = 1'b0; just[p] = 1'b0; pr_req[p] = 1'b0; pr_ack[p] = 1'b0;
      end
      for (int c = 0; c < 500; c++) begin
         run = c < 400;
         if (!run && !pend[0] && !pend[1]) break;
         tick();
         if (mem_req && !prev_mreq) begin
            e0 = pr_req[0] && !pr_ack[0];
            e1 = pr_req[1] && !pr_ack[1];
            g = (e0 && e1) ? 1 - last_w : (e1 ? 1 : 0);
            checks++; if (!(e0 || e1) || !pend[g] || granted[g]) begin fails++; $display("FAIL rand_grant[%0d]: got grant with elig=%b%b pend=%b want eligible port %0d", s, e1, e0, pend[g], g); end
            last_w = g; cur = g; granted[g] = 1'b1; busy = 0; cur_wait = wait_cfg;
         end
         if (!mem_req && !prev_mreq && ((pr_req[0] && !pr_ack[0]) || (pr_req[1] && !pr_ack[1]))) begin
            checks++; fails++; $display("FAIL rand_missed_grant[%0d]: got idle want grant (req=%b%b)", s, pr_req[1], pr_req[0]);
         end
         if (mem_req) begin
            busy++;
            checks++;
            if (mem_addr !== t_addr[cur] || mem_w !== t_we[cur] || (t_we[cur] && mem_wdata !== t_wd[cur]) || ack !== 2'b00) begin
               fails++; $display("FAIL rand_busy[%0d]: got addr=%h w=%b data=%h ack=%b want %h %b %h 00", s, mem_addr, mem_w, mem_wdata, ack, t_addr[cur], t_we[cur], t_wd[cur]);
            end
         end else if (prev_mreq) begin
            n = cur_wait + 1 < limit ? cur_wait + 1 : limit;
            to = cur_wait + 1 > limit;
            checks++; if (busy != n) begin fails++; $display("FAIL rand_len[%0d]: got %0d busy cycles want %0d", s, busy, n); end
            checks++; if (ack[cur] !== 1'b1 || ack[1-cur] !== 1'b0 || err[cur] !== to || err[1-cur] !== 1'b0) begin
               fails++; $display("FAIL rand_ack[%0d]: got ack=%b err=%b want port %0d err=%b", s, ack, err, cur, to);
            end
            if (to) exp_rd[cur] = '0;
            else if (!t_we[cur]) exp_rd[cur] = ref_mem[t_addr[cur][3:0]];
            else ref_mem[t_addr[cur][3:0]] = t_wd[cur];
            pend[cur] = 1'b0; granted[cur] = 1'b0; just[cur] = 1'b1;
            drive(cur, 1'b0, t_we[cur], t_addr[cur], t_wd[cur]);
         end else begin
            checks++; if ({ack, err} !== 4'b0) begin fails++; $display("FAIL rand_spurious[%0d]: got ack=%b err=%b want 0", s, ack, err); end
         end
         checks++; if (rd0 !== exp_rd[0] || rd1 !== exp_rd[1]) begin fails++; $display("FAIL rand_rdata[%0d]: got %h %h want %h %h", s, rd0, rd1, exp_rd[0], exp_rd[1]); end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && !just[p] && run && $urandom_range(0, 2) == 0) begin
               pend[p] = 1'b1; t_we[p] = 1'($urandom); t_addr[p] = 16'($urandom); t_wd[p] = 16'($urandom);
               drive(p, 1'b1, t_we[p], t_addr[p], t_wd[p]);
            end else if (granted[p]) begin
               drive(p, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
            end
            just[p] = 1'b0;
            pr_req[p] = pend[p];
            pr_ack[p] = ack[p];
         end
         if (!mem_req) wait_cfg = s ? $urandom_range(0, 6) : $urandom_range(0, 3);
         prev_mreq = mem_req;
      end
      checks++; if (pend[0] || pend[1]) begin fails++; $display("FAIL rand_drain[%0d]: got pending=%b%b want 00", s, pend[1], pend[0]); end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      test_reset();
      test_read_zero_wait();
      test_round_robin();
      test_write_stable();
      test_timeout();
      test_timeout_edge();
      test_async_reset();
      test_random(1'b0);
      test_random(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
